// File: rtl/dcu_huff_pkg.sv
// Shared Huffman builder definitions for the DCU encoder tables.
package dcu_huff_pkg;
  localparam int NSYM   = 16;
  localparam int LW     = 4;
  localparam int MAXLEN = 8;
  localparam int CW     = MAXLEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } huff_state_t;

  // Reverse the low l bits of c (l <= CW). Bits at or above l are zero.
  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] c, input logic [LW-1:0] l);
    logic [CW-1:0] r;
    logic [2:0]    idx;
    r = '0;
    for (int j = 0; j < CW; j++) begin
      idx = 3'(int'(l) - 1 - j);
      if (j < int'(l)) r[j] = c[idx];
    end
    return r;
  endfunction
endpackage

// File: rtl/cl_code_table.sv
// Symbol -> {code, length} register file with one write port and a
// registered lookup port. Lookups can be forced to 0/0 while the table
// is not ready.
module cl_code_table
  import dcu_huff_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [CW-1:0] wcode,
  input  logic [LW-1:0] wlen,
  input  logic          rd_en,
  input  logic [3:0]    raddr,
  input  logic          rd_zero,
  output logic          rvalid,
  output logic [CW-1:0] rcode,
  output logic [LW-1:0] rlen
);

  logic [NSYM-1:0][CW-1:0] code_q;
  logic [NSYM-1:0][LW-1:0] len_q;

  // Entry storage: cleared on reset and on a rebuild, written one entry per match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      len_q  <= '0;
    end else if (clr) begin
      code_q <= '0;
      len_q  <= '0;
    end else if (we) begin
      code_q[waddr] <= wcode;
      len_q[waddr]  <= wlen;
    end
  end

  // Registered read; result holds between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rcode  <= '0;
      rlen   <= '0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rcode <= rd_zero ? '0 : code_q[raddr];
        rlen  <= rd_zero ? '0 : len_q[raddr];
      end
    end
  end

endmodule

// File: rtl/cl_code_dist_enc.sv
// Canonical Huffman code builder for the 16-symbol distance alphabet.
// Scans length 1..8 x symbol 0..15, one position per cycle, assigning
// consecutive codes to matching symbols and storing them bit-reversed.
module cl_code_dist_enc
  import dcu_huff_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] distTree,
  output logic        busy,
  output logic        done,
  output logic        over_err,
  input  logic        sym_valid,
  input  logic [3:0]  sym_in,
  output logic        code_valid,
  output logic [7:0]  code_out,
  output logic [3:0]  code_len
);

  huff_state_t             state, nstate;
  logic [NSYM-1:0][LW-1:0] tree_q;
  logic [LW-1:0]           len_cnt;
  logic [3:0]              pos;
  logic [8:0]              code;
  logic [8:0]              code_inc;
  logic                    start_acc;
  logic                    match;
  logic                    ovf;
  logic                    last;
  logic                    bad_len;

  assign start_acc = start && (state != ST_SCAN);
  assign match     = (state == ST_SCAN) && (tree_q[pos] == len_cnt);
  assign code_inc  = code + 9'(match);
  assign ovf       = code >= (9'd1 << len_cnt);
  assign last      = (len_cnt == LW'(MAXLEN)) && (pos == 4'(NSYM-1));

  // Any incoming length field beyond MAXLEN is an immediate error.
  always_comb begin
    bad_len = 1'b0;
    for (int i = 0; i < NSYM; i++)
      if (distTree[LW*i +: LW] > LW'(MAXLEN)) bad_len = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  // Next-state logic; start is ignored while scanning.
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (start) nstate = ST_SCAN;
      ST_SCAN: if (last)  nstate = ST_DONE;
      ST_DONE: if (start) nstate = ST_SCAN;
      default: nstate = ST_IDLE;
    endcase
  end

  // Scan counters and the canonical code counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q  <= '0;
      len_cnt <= '0;
      pos     <= '0;
      code    <= '0;
    end else if (start_acc) begin
      tree_q  <= distTree;
      len_cnt <= LW'(1);
      pos     <= '0;
      code    <= '0;
    end else if (state == ST_SCAN) begin
      if (pos == 4'(NSYM-1)) begin
        pos     <= '0;
        len_cnt <= len_cnt + LW'(1);
        code    <= code_inc << 1;
      end else begin
        pos     <= pos + 4'd1;
        code    <= code_inc;
      end
    end
  end

  // Status flags: busy/done trail the state by one edge; over_err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      over_err <= 1'b0;
    end else begin
      busy <= (state == ST_SCAN);
      done <= (state == ST_DONE) && !start;
      if (start_acc)         over_err <= bad_len;
      else if (match && ovf) over_err <= 1'b1;
    end
  end

  cl_code_table u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_acc),
    .we      (match),
    .waddr   (pos),
    .wcode   (bitrev(code[7:0], len_cnt)),
    .wlen    (len_cnt),
    .rd_en   (sym_valid),
    .raddr   (sym_in),
    .rd_zero (!done || start_acc),
    .rvalid  (code_valid),
    .rcode   (code_out),
    .rlen    (code_len)
  );

endmodule

// File: tb/tb_cl_code_dist_enc.sv
// Bench for cl_code_dist_enc: directed vector table, hand-written
// multi-cycle sequences and randomized trees against a reference model.
module tb_cl_code_dist_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] distTree;
  logic        busy, done, over_err;
  logic        sym_valid;
  logic [3:0]  sym_in;
  logic        code_valid;
  logic [7:0]  code_out;
  logic [3:0]  code_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cl_code_dist_enc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .distTree   (distTree),
    .busy       (busy),
    .done       (done),
    .over_err   (over_err),
    .sym_valid  (sym_valid),
    .sym_in     (sym_in),
    .code_valid (code_valid),
    .code_out   (code_out),
    .code_len   (code_len)
  );

  typedef struct {
    logic [63:0] tree;
    logic [3:0]  sym;
    logic [7:0]  code;
    logic [3:0]  len;
    logic        err;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse at edge 0, then check busy/done timing through edge 129.
  task automatic build(input logic [63:0] t);
    distTree = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_e0", 32'(busy), 0);
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (k == 1) chk("busy_e1", 32'(busy), 1);
    end
    chk("busy_e128", 32'(busy), 1);
    chk("done_e128", 32'(done), 0);
    tick();
    chk("busy_e129", 32'(busy), 0);
    chk("done_e129", 32'(done), 1);
  endtask

  task automatic lookup(input string name, input logic [3:0] s, input logic [7:0] c, input logic [3:0] l);
    sym_valid = 1'b1;
    sym_in = s;
    tick();
    sym_valid = 1'b0;
    chk({name, "_vld"}, 32'(code_valid), 1);
    chk({name, "_code"}, 32'(code_out), 32'(c));
    chk({name, "_len"}, 32'(code_len), 32'(l));
  endtask

  // Canonical assignment from the rules: lengths ascending, symbols
  // ascending within a length; 9-bit counter; codes reversed LSB-first.
  task automatic model(input logic [63:0] t, output logic [15:0][7:0] mc,
                       output logic [15:0][3:0] ml, output logic merr);
    int code;
    int f;
    mc = '0;
    ml = '0;
    merr = 1'b0;
    code = 0;
    for (int i = 0; i < 16; i++)
      if (int'(t[4*i +: 4]) > 8) merr = 1'b1;
    for (int L = 1; L <= 8; L++) begin
      for (int i = 0; i < 16; i++) begin
        f = int'(t[4*i +: 4]);
        if (f == L) begin
          if (code >= (1 << L)) merr = 1'b1;
          ml[i] = 4'(L);
          for (int j = 0; j < L; j++)
            mc[i][j] = 1'((code >> (L - 1 - j)) & 1);
          code = (code + 1) % 512;
        end
      end
      code = (code * 2) % 512;
    end
  endtask

  initial begin
    logic [63:0]       cur;
    logic [63:0]       t;
    logic [15:0][7:0]  mc;
    logic [15:0][3:0]  ml;
    logic              merr;
    int                r;
    int                s;

    vt[0]  = '{64'h4444_4444_4444_4444, 4'd5,  8'h0A, 4'd4, 1'b0};
    vt[1]  = '{64'h4444_4444_4444_4444, 4'd15, 8'h0F, 4'd4, 1'b0};
    vt[2]  = '{64'h4444_4444_4444_4444, 4'd0,  8'h00, 4'd4, 1'b0};
    vt[3]  = '{64'h0000_0000_4423_3333, 4'd5,  8'h00, 4'd2, 1'b0};
    vt[4]  = '{64'h0000_0000_4423_3333, 4'd0,  8'h02, 4'd3, 1'b0};
    vt[5]  = '{64'h0000_0000_4423_3333, 4'd1,  8'h06, 4'd3, 1'b0};
    vt[6]  = '{64'h0000_0000_4423_3333, 4'd4,  8'h03, 4'd3, 1'b0};
    vt[7]  = '{64'h0000_0000_4423_3333, 4'd6,  8'h07, 4'd4, 1'b0};
    vt[8]  = '{64'h0000_0000_4423_3333, 4'd7,  8'h0F, 4'd4, 1'b0};
    vt[9]  = '{64'h0000_0000_4423_3333, 4'd9,  8'h00, 4'd0, 1'b0};
    vt[10] = '{64'h0000_0000_0000_0111, 4'd0,  8'h00, 4'd1, 1'b1};
    vt[11] = '{64'h0000_0000_0000_0111, 4'd1,  8'h01, 4'd1, 1'b1};
    vt[12] = '{64'h0000_0000_0000_C221, 4'd0,  8'h00, 4'd1, 1'b1};
    vt[13] = '{64'h0000_0000_0000_C221, 4'd1,  8'h01, 4'd2, 1'b1};
    vt[14] = '{64'h0000_0000_0000_C221, 4'd2,  8'h03, 4'd2, 1'b1};
    vt[15] = '{64'h0000_0000_0000_C221, 4'd3,  8'h00, 4'd0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    distTree = '0;
    sym_valid = 1'b0;
    sym_in = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(over_err), 0);
    chk("rst_vld", 32'(code_valid), 0);
    chk("rst_code", 32'(code_out), 0);
    chk("rst_len", 32'(code_len), 0);
    rst_n = 1'b1;
    tick();

    // Directed table.
    cur = '1;
    for (int i = 0; i < 16; i++) begin
      if (vt[i].tree != cur) begin
        build(vt[i].tree);
        cur = vt[i].tree;
      end
      lookup($sformatf("vec%0d", i), vt[i].sym, vt[i].code, vt[i].len);
      chk($sformatf("vec%0d_err", i), 32'(over_err), 32'(vt[i].err));
    end

    // Output hold when no request.
    tick();
    chk("hold_vld", 32'(code_valid), 0);
    chk("hold_len", 32'(code_len), 0);

    // over_err rises exactly at the sym-2 match (edge 3); err-at-start case.
    distTree = 64'h111;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err3_e0", 32'(over_err), 0);
    tick();
    tick();
    chk("err3_e2", 32'(over_err), 0);
    tick();
    chk("err3_e3", 32'(over_err), 1);
    for (int k = 4; k <= 129; k++) tick();
    chk("err3_done", 32'(done), 1);
    distTree = 64'hC221;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err12_e0", 32'(over_err), 1);
    for (int k = 1; k <= 129; k++) tick();

    // Lookup and ignored start during SCAN.
    distTree = 64'h4444_4444_4444_4444;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      if (k == 11) begin
        start = 1'b1;
        distTree = 64'h0000_0000_4423_3333;
        sym_valid = 1'b1;
        sym_in = 4'd5;
      end
      tick();
      if (k == 11) begin
        start = 1'b0;
        sym_valid = 1'b0;
        chk("scan_vld", 32'(code_valid), 1);
        chk("scan_code", 32'(code_out), 0);
        chk("scan_len", 32'(code_len), 0);
      end
    end
    chk("ign_done128", 32'(done), 0);
    tick();
    chk("ign_done129", 32'(done), 1);
    lookup("ign_sym5", 4'd5, 8'h0A, 4'd4);

    // Lookup in the same cycle as an accepted start returns 0/0.
    distTree = 64'h4444_4444_4444_4444;
    start = 1'b1;
    sym_valid = 1'b1;
    sym_in = 4'd15;
    tick();
    start = 1'b0;
    sym_valid = 1'b0;
    chk("sst_vld", 32'(code_valid), 1);
    chk("sst_code", 32'(code_out), 0);
    chk("sst_len", 32'(code_len), 0);
    chk("sst_done", 32'(done), 0);
    for (int k = 1; k <= 129; k++) tick();
    chk("sst_done129", 32'(done), 1);
    lookup("pre_rst", 4'd15, 8'h0F, 4'd4);

    // Asynchronous reset in the middle of a scan.
    distTree = 64'h4444_4444_4444_444C;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 59; k++) tick();
    chk("mid_busy", 32'(busy), 1);
    chk("mid_err", 32'(over_err), 1);
    chk("mid_hold", 32'(code_out), 32'h0F);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(over_err), 0);
    chk("arst_vld", 32'(code_valid), 0);
    chk("arst_code", 32'(code_out), 0);
    chk("arst_len", 32'(code_len), 0);
    tick();
    rst_n = 1'b1;
    tick();
    lookup("idle_lk", 4'd15, 8'h00, 4'd0);

    // Randomized trees against the reference model, back-to-back lookups.
    for (int n = 0; n < 8; n++) begin
      t = '0;
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 20)      t[4*i +: 4] = 4'd0;
        else if (r < 93) t[4*i +: 4] = 4'($urandom_range(1, 8));
        else             t[4*i +: 4] = 4'($urandom_range(9, 15));
      end
      model(t, mc, ml, merr);
      build(t);
      chk($sformatf("rnd%0d_err", n), 32'(over_err), 32'(merr));
      for (int q = 0; q < 20; q++) begin
        s = int'($urandom_range(0, 15));
        sym_valid = 1'b1;
        sym_in = 4'(s);
        tick();
        chk($sformatf("rnd%0d_s%0d_vld", n, s), 32'(code_valid), 1);
        chk($sformatf("rnd%0d_s%0d_code", n, s), 32'(code_out), 32'(mc[s]));
        chk($sformatf("rnd%0d_s%0d_len", n, s), 32'(code_len), 32'(ml[s]));
      end
      sym_valid = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
